// File: rtl/vlb_miss_ctl.sv
// vlb_miss_ctl: tracks up to N outstanding VLB misses, issues them to the FST and returns results.
// Optional build macro VLB_MISS_MERGE_EN merges a miss into a live entry with the same VPN.
module vlb_miss_ctl #(
  parameter int unsigned N      = 4,
  parameter int unsigned IDX_W  = $clog2(N),
  parameter int unsigned VPN_W  = 52,
  parameter int unsigned MPN_W  = 52,
  parameter int unsigned ATTR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              miss_i_valid,
  output logic              miss_i_ready,
  input  logic [VPN_W-1:0]  miss_i_vpn,
  output logic              done_o_valid,
  input  logic              done_o_ready,
  output logic [VPN_W-1:0]  done_o_vpn,
  output logic              done_o_err,
  output logic [MPN_W-1:0]  done_o_mpn,
  output logic [ATTR_W-1:0] done_o_attr,
  input  logic              flush_i,
  output logic              vlb_req_o_valid,
  output logic [IDX_W-1:0]  vlb_req_o_bits_idx,
  output logic [VPN_W-1:0]  vlb_req_o_bits_vpn,
  output logic              vlb_req_o_bits_kill,
  input  logic              vlb_resp_i_valid,
  input  logic [IDX_W-1:0]  vlb_resp_i_bits_idx,
  input  logic              vlb_resp_i_bits_vld,
  input  logic              vlb_resp_i_bits_err,
  input  logic [MPN_W-1:0]  vlb_resp_i_bits_mpn,
  input  logic [ATTR_W-1:0] vlb_resp_i_bits_attr,
  input  logic              vlb_fill_i_valid,
  input  logic [IDX_W-1:0]  vlb_fill_i_bits_idx,
  input  logic              vlb_fill_i_bits_vld,
  input  logic              vlb_fill_i_bits_err,
  input  logic [MPN_W-1:0]  vlb_fill_i_bits_mpn,
  input  logic [ATTR_W-1:0] vlb_fill_i_bits_attr,
  output logic              vlb_kill_o,
  input  logic              vlb_busy_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PEND = 3'd1;
  localparam logic [2:0] S_SENT = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        st_q   [N];
  logic [VPN_W-1:0]  vpn_q  [N];
  logic              err_q  [N];
  logic [MPN_W-1:0]  mpn_q  [N];
  logic [ATTR_W-1:0] attr_q [N];

  logic             kill_q, drain_q, lock_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic             any_idle, any_pend, any_done;
  logic [IDX_W-1:0] idle_idx, pend_idx, first_done_idx, done_idx;
  logic             accept_ok, alloc_en, issue_en, done_fire;

`ifdef VLB_MISS_MERGE_EN
  logic [2:0]       cnt_q [N];
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
`endif

  always_comb begin
    any_idle       = 1'b0;
    any_pend       = 1'b0;
    any_done       = 1'b0;
    idle_idx       = '0;
    pend_idx       = '0;
    first_done_idx = '0;
`ifdef VLB_MISS_MERGE_EN
    hit            = 1'b0;
    hit_idx        = '0;
`endif
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_idle && st_q[i] == S_IDLE) begin
        any_idle = 1'b1;
        idle_idx = i[IDX_W-1:0];
      end
      if (!any_pend && st_q[i] == S_PEND) begin
        any_pend = 1'b1;
        pend_idx = i[IDX_W-1:0];
      end
      if (!any_done && st_q[i] == S_DONE) begin
        any_done       = 1'b1;
        first_done_idx = i[IDX_W-1:0];
      end
`ifdef VLB_MISS_MERGE_EN
      if (!hit && vpn_q[i] == miss_i_vpn &&
          (st_q[i] == S_PEND || st_q[i] == S_SENT || st_q[i] == S_WAIT)) begin
        hit     = 1'b1;
        hit_idx = i[IDX_W-1:0];
      end
`endif
    end
  end

  assign accept_ok = !reset && !flush_i && !drain_q;
`ifdef VLB_MISS_MERGE_EN
  assign miss_i_ready = accept_ok && (hit ? (cnt_q[hit_idx] != 3'd7) : any_idle);
  assign alloc_en     = miss_i_valid && miss_i_ready && !hit;
`else
  assign miss_i_ready = accept_ok && any_idle;
  assign alloc_en     = miss_i_valid && miss_i_ready;
`endif

  assign issue_en            = !reset && any_pend && !vlb_busy_i && !flush_i && !drain_q;
  assign vlb_req_o_valid     = issue_en;
  assign vlb_req_o_bits_idx  = issue_en ? pend_idx : '0;
  assign vlb_req_o_bits_vpn  = issue_en ? vpn_q[pend_idx] : '0;
  assign vlb_req_o_bits_kill = 1'b0;
  assign vlb_kill_o          = kill_q;

  // Once presented, the selected entry stays locked until consumed so a lower
  // index completing later cannot change done_o_* mid-handshake.
  assign done_idx     = lock_q ? lock_idx_q : first_done_idx;
  assign done_o_valid = !reset && (st_q[done_idx] == S_DONE);
  assign done_fire    = done_o_valid && done_o_ready;
  assign done_o_vpn   = done_o_valid ? vpn_q[done_idx]  : '0;
  assign done_o_err   = done_o_valid ? err_q[done_idx]  : 1'b0;
  assign done_o_mpn   = done_o_valid ? mpn_q[done_idx]  : '0;
  assign done_o_attr  = done_o_valid ? attr_q[done_idx] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      kill_q     <= 1'b0;
      drain_q    <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        st_q[i]   <= S_IDLE;
        vpn_q[i]  <= '0;
        err_q[i]  <= 1'b0;
        mpn_q[i]  <= '0;
        attr_q[i] <= '0;
`ifdef VLB_MISS_MERGE_EN
        cnt_q[i]  <= '0;
`endif
      end
    end else begin
      kill_q <= flush_i;
      // Drain cannot end in the kill cycle; it waits for the FST to report idle afterwards.
      if (flush_i)
        drain_q <= 1'b1;
      else if (drain_q && !kill_q && !vlb_busy_i)
        drain_q <= 1'b0;

      if (flush_i || done_fire)
        lock_q <= 1'b0;
      else if (done_o_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= done_idx;
      end

      for (int unsigned i = 0; i < N; i++) begin
        if (flush_i) begin
          st_q[i] <= S_IDLE;
`ifdef VLB_MISS_MERGE_EN
          cnt_q[i] <= '0;
`endif
        end else begin
          case (st_q[i])
            S_IDLE: if (alloc_en && idle_idx == i[IDX_W-1:0]) begin
              st_q[i]  <= S_PEND;
              vpn_q[i] <= miss_i_vpn;
`ifdef VLB_MISS_MERGE_EN
              cnt_q[i] <= '0;
`endif
            end
            S_PEND: if (issue_en && pend_idx == i[IDX_W-1:0]) st_q[i] <= S_SENT;
            S_SENT, S_WAIT: begin
              if (vlb_fill_i_valid && vlb_fill_i_bits_idx == i[IDX_W-1:0]) begin
                st_q[i]   <= S_DONE;
                err_q[i]  <= vlb_fill_i_bits_err;
                mpn_q[i]  <= vlb_fill_i_bits_mpn;
                attr_q[i] <= vlb_fill_i_bits_attr;
              end else if (vlb_resp_i_valid && vlb_resp_i_bits_idx == i[IDX_W-1:0]) begin
                if (vlb_resp_i_bits_vld) begin
                  st_q[i]   <= S_DONE;
                  err_q[i]  <= vlb_resp_i_bits_err;
                  mpn_q[i]  <= vlb_resp_i_bits_mpn;
                  attr_q[i] <= vlb_resp_i_bits_attr;
                end else begin
                  st_q[i] <= S_WAIT;
                end
              end
            end
            S_DONE: if (done_fire && done_idx == i[IDX_W-1:0]) begin
`ifdef VLB_MISS_MERGE_EN
              if (cnt_q[i] != 3'd0) cnt_q[i] <= cnt_q[i] - 3'd1;
              else                  st_q[i]  <= S_IDLE;
`else
              st_q[i] <= S_IDLE;
`endif
            end
            default: st_q[i] <= S_IDLE;
          endcase
`ifdef VLB_MISS_MERGE_EN
          if (miss_i_valid && miss_i_ready && hit && hit_idx == i[IDX_W-1:0])
            cnt_q[i] <= cnt_q[i] + 3'd1;
`endif
        end
      end
    end
  end

  resp_fill_clash: assert property (@(posedge clock) disable iff (reset)
    !(vlb_resp_i_valid && vlb_resp_i_bits_vld && vlb_fill_i_valid &&
      vlb_resp_i_bits_idx == vlb_fill_i_bits_idx));

endmodule

// File: tb/tb_vlb_miss_ctl.sv
// tb_vlb_miss_ctl: directed scoreboard bench for vlb_miss_ctl (N=4, default widths).
// Expected FST requests and done results are queued at stimulus time and popped by a monitor.
module tb_vlb_miss_ctl;

  typedef struct packed {
    logic [1:0]  idx;
    logic [51:0] vpn;
  } req_t;

  typedef struct packed {
    logic [51:0] vpn;
    logic        err;
    logic [51:0] mpn;
    logic [3:0]  attr;
  } done_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        miss_i_valid, miss_i_ready;
  logic [51:0] miss_i_vpn;
  logic        done_o_valid, done_o_ready, done_o_err;
  logic [51:0] done_o_vpn, done_o_mpn;
  logic [3:0]  done_o_attr;
  logic        flush_i;
  logic        vlb_req_o_valid, vlb_req_o_bits_kill;
  logic [1:0]  vlb_req_o_bits_idx;
  logic [51:0] vlb_req_o_bits_vpn;
  logic        vlb_resp_i_valid, vlb_resp_i_bits_vld, vlb_resp_i_bits_err;
  logic [1:0]  vlb_resp_i_bits_idx;
  logic [51:0] vlb_resp_i_bits_mpn;
  logic [3:0]  vlb_resp_i_bits_attr;
  logic        vlb_fill_i_valid, vlb_fill_i_bits_vld, vlb_fill_i_bits_err;
  logic [1:0]  vlb_fill_i_bits_idx;
  logic [51:0] vlb_fill_i_bits_mpn;
  logic [3:0]  vlb_fill_i_bits_attr;
  logic        vlb_kill_o, vlb_busy_i;

  int total = 0;
  int bad   = 0;
  req_t  req_q[$];
  done_t done_q[$];

  always #5 clock = ~clock;

  vlb_miss_ctl #(.N(4), .VPN_W(52), .MPN_W(52), .ATTR_W(4)) dut (
    .clock(clock), .reset(reset),
    .miss_i_valid(miss_i_valid), .miss_i_ready(miss_i_ready), .miss_i_vpn(miss_i_vpn),
    .done_o_valid(done_o_valid), .done_o_ready(done_o_ready), .done_o_vpn(done_o_vpn),
    .done_o_err(done_o_err), .done_o_mpn(done_o_mpn), .done_o_attr(done_o_attr),
    .flush_i(flush_i),
    .vlb_req_o_valid(vlb_req_o_valid), .vlb_req_o_bits_idx(vlb_req_o_bits_idx),
    .vlb_req_o_bits_vpn(vlb_req_o_bits_vpn), .vlb_req_o_bits_kill(vlb_req_o_bits_kill),
    .vlb_resp_i_valid(vlb_resp_i_valid), .vlb_resp_i_bits_idx(vlb_resp_i_bits_idx),
    .vlb_resp_i_bits_vld(vlb_resp_i_bits_vld), .vlb_resp_i_bits_err(vlb_resp_i_bits_err),
    .vlb_resp_i_bits_mpn(vlb_resp_i_bits_mpn), .vlb_resp_i_bits_attr(vlb_resp_i_bits_attr),
    .vlb_fill_i_valid(vlb_fill_i_valid), .vlb_fill_i_bits_idx(vlb_fill_i_bits_idx),
    .vlb_fill_i_bits_vld(vlb_fill_i_bits_vld), .vlb_fill_i_bits_err(vlb_fill_i_bits_err),
    .vlb_fill_i_bits_mpn(vlb_fill_i_bits_mpn), .vlb_fill_i_bits_attr(vlb_fill_i_bits_attr),
    .vlb_kill_o(vlb_kill_o), .vlb_busy_i(vlb_busy_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push_req(input logic [1:0] idx, input logic [51:0] vpn);
    req_t r;
    r.idx = idx;
    r.vpn = vpn;
    req_q.push_back(r);
  endtask

  task automatic push_done(input logic [51:0] vpn, input logic err,
                           input logic [51:0] mpn, input logic [3:0] attr);
    done_t d;
    d.vpn = vpn; d.err = err; d.mpn = mpn; d.attr = attr;
    done_q.push_back(d);
  endtask

  task automatic resp(input logic [1:0] idx, input logic vld, input logic err,
                      input logic [51:0] mpn, input logic [3:0] attr);
    vlb_resp_i_valid = 1'b1; vlb_resp_i_bits_idx = idx; vlb_resp_i_bits_vld = vld;
    vlb_resp_i_bits_err = err; vlb_resp_i_bits_mpn = mpn; vlb_resp_i_bits_attr = attr;
  endtask

  task automatic miss(input logic [51:0] vpn);
    miss_i_valid = 1'b1;
    miss_i_vpn   = vpn;
  endtask

  // Monitor: every request and every consumed done result must match the queue head.
  always @(negedge clock) begin
    if (!reset) begin
      if (vlb_req_o_valid) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req_idx", 64'(vlb_req_o_bits_idx), 64'hdead);
        end else begin
          req_t e;
          e = req_q.pop_front();
          chk("req_idx", 64'(vlb_req_o_bits_idx), 64'(e.idx));
          chk("req_vpn", 64'(vlb_req_o_bits_vpn), 64'(e.vpn));
          chk("req_kill", 64'(vlb_req_o_bits_kill), 64'h0);
        end
      end
      if (done_o_valid && done_o_ready) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done_vpn", 64'(done_o_vpn), 64'hdead);
        end else begin
          done_t e;
          e = done_q.pop_front();
          chk("done_vpn", 64'(done_o_vpn), 64'(e.vpn));
          chk("done_err", 64'(done_o_err), 64'(e.err));
          chk("done_mpn", 64'(done_o_mpn), 64'(e.mpn));
          chk("done_attr", 64'(done_o_attr), 64'(e.attr));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; miss_i_valid = 1'b0; miss_i_vpn = '0; done_o_ready = 1'b1;
    flush_i = 1'b0; vlb_busy_i = 1'b0;
    vlb_resp_i_valid = 1'b0; vlb_resp_i_bits_idx = '0; vlb_resp_i_bits_vld = 1'b0;
    vlb_resp_i_bits_err = 1'b0; vlb_resp_i_bits_mpn = '0; vlb_resp_i_bits_attr = '0;
    vlb_fill_i_valid = 1'b0; vlb_fill_i_bits_idx = '0; vlb_fill_i_bits_vld = 1'b0;
    vlb_fill_i_bits_err = 1'b0; vlb_fill_i_bits_mpn = '0; vlb_fill_i_bits_attr = '0;

    repeat (3) cyc();
    @(negedge clock);
    chk("rst_ready", 64'(miss_i_ready), 64'h0);
    chk("rst_req", 64'(vlb_req_o_valid), 64'h0);
    chk("rst_done", 64'(done_o_valid), 64'h0);
    chk("rst_kill", 64'(vlb_kill_o), 64'h0);
    cyc();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", 64'(miss_i_ready), 64'h1);
    cyc();

    // single miss, immediate response
    miss(52'h123); push_req(2'd0, 52'h123);
    @(negedge clock); chk("t1_ready", 64'(miss_i_ready), 64'h1);
    cyc();
    miss_i_valid = 1'b0;
    @(negedge clock); chk("t1_req_next_cycle", 64'(vlb_req_o_valid), 64'h1);
    cyc();
    resp(2'd0, 1'b1, 1'b0, 52'h456, 4'h5); push_done(52'h123, 1'b0, 52'h456, 4'h5);
    @(negedge clock); chk("t1_done_not_yet", 64'(done_o_valid), 64'h0);
    cyc();
    vlb_resp_i_valid = 1'b0;
    @(negedge clock); chk("t1_done_latency", 64'(done_o_valid), 64'h1);
    cyc();
    @(negedge clock); chk("t1_done_clear", 64'(done_o_valid), 64'h0);
    cyc();

    // resp vld=0 then late fill with error
    miss(52'h200); push_req(2'd0, 52'h200);
    cyc();
    miss_i_valid = 1'b0;
    cyc();
    resp(2'd0, 1'b0, 1'b0, 52'h0, 4'h0);
    cyc();
    vlb_resp_i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); chk("t2_wait_no_done", 64'(done_o_valid), 64'h0);
      cyc();
    end
    vlb_fill_i_valid = 1'b1; vlb_fill_i_bits_idx = 2'd0; vlb_fill_i_bits_vld = 1'b1;
    vlb_fill_i_bits_err = 1'b1; vlb_fill_i_bits_mpn = 52'h999; vlb_fill_i_bits_attr = 4'h3;
    push_done(52'h200, 1'b1, 52'h999, 4'h3);
    @(negedge clock); chk("t2_fill_not_yet", 64'(done_o_valid), 64'h0);
    cyc();
    vlb_fill_i_valid = 1'b0;
    @(negedge clock); chk("t2_fill_done", 64'(done_o_valid), 64'h1);
    cyc();

    // fill all four entries, fifth miss held off until a slot frees
    for (int k = 0; k < 4; k++) begin
      miss(52'h10 + 52'(k)); push_req(2'(k), 52'h10 + 52'(k));
      cyc();
    end
    miss(52'h14);
    @(negedge clock); chk("t3_full_ready", 64'(miss_i_ready), 64'h0);
    cyc();
    resp(2'd2, 1'b1, 1'b0, 52'h222, 4'h2); push_done(52'h12, 1'b0, 52'h222, 4'h2);
    @(negedge clock); chk("t3_full_ready2", 64'(miss_i_ready), 64'h0);
    cyc();
    vlb_resp_i_valid = 1'b0;
    @(negedge clock);
    chk("t3_done_idx2_vpn", 64'(done_o_vpn), 64'h12);
    chk("t3_ready_during_hs", 64'(miss_i_ready), 64'h0);
    cyc();
    push_req(2'd2, 52'h14);
    @(negedge clock); chk("t3_freed_ready", 64'(miss_i_ready), 64'h1);
    cyc();
    miss_i_valid = 1'b0;
    cyc();
    // hold: a lower index completing must not displace the presented one
    done_o_ready = 1'b0;
    resp(2'd1, 1'b1, 1'b0, 52'h111, 4'h1); push_done(52'h11, 1'b0, 52'h111, 4'h1);
    cyc();
    resp(2'd0, 1'b1, 1'b0, 52'h100, 4'h0); push_done(52'h10, 1'b0, 52'h100, 4'h0);
    @(negedge clock); chk("t3_first_vpn", 64'(done_o_vpn), 64'h11);
    cyc();
    vlb_resp_i_valid = 1'b0;
    @(negedge clock);
    chk("t3_hold_valid", 64'(done_o_valid), 64'h1);
    chk("t3_hold_vpn", 64'(done_o_vpn), 64'h11);
    cyc();
    done_o_ready = 1'b1;
    cyc();
    resp(2'd3, 1'b1, 1'b0, 52'h133, 4'h3); push_done(52'h13, 1'b0, 52'h133, 4'h3);
    cyc();
    resp(2'd2, 1'b1, 1'b0, 52'h144, 4'h4); push_done(52'h14, 1'b0, 52'h144, 4'h4);
    cyc();
    vlb_resp_i_valid = 1'b0;
    cyc();
    @(negedge clock); chk("t3_all_drained", 64'(done_o_valid), 64'h0);
    cyc();

    // FST busy blocks issue
    vlb_busy_i = 1'b1;
    miss(52'h30); push_req(2'd0, 52'h30);
    cyc();
    miss(52'h31); push_req(2'd1, 52'h31);
    cyc();
    miss_i_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock); chk("t4_busy_no_req", 64'(vlb_req_o_valid), 64'h0);
      cyc();
    end
    vlb_busy_i = 1'b0;
    @(negedge clock);
    chk("t4_issue0", 64'(vlb_req_o_valid), 64'h1);
    chk("t4_issue0_idx", 64'(vlb_req_o_bits_idx), 64'h0);
    cyc();
    @(negedge clock);
    chk("t4_issue1", 64'(vlb_req_o_valid), 64'h1);
    chk("t4_issue1_idx", 64'(vlb_req_o_bits_idx), 64'h1);
    cyc();
    miss(52'h32); push_req(2'd2, 52'h32);
    cyc();
    miss_i_valid = 1'b0;
    cyc();

    // flush with three SENT entries
    vlb_busy_i = 1'b1; flush_i = 1'b1; miss(52'h40);
    @(negedge clock); chk("t5_flush_miss_ready", 64'(miss_i_ready), 64'h0);
    cyc();
    flush_i = 1'b0; miss_i_valid = 1'b0;
    resp(2'd1, 1'b1, 1'b0, 52'h555, 4'h5);
    @(negedge clock);
    chk("t5_kill_pulse", 64'(vlb_kill_o), 64'h1);
    chk("t5_ready_kill", 64'(miss_i_ready), 64'h0);
    cyc();
    vlb_resp_i_valid = 1'b0;
    @(negedge clock);
    chk("t5_kill_end", 64'(vlb_kill_o), 64'h0);
    chk("t5_late_resp_dropped", 64'(done_o_valid), 64'h0);
    chk("t5_drain_ready", 64'(miss_i_ready), 64'h0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); chk("t5_drain_busy", 64'(miss_i_ready), 64'h0);
      cyc();
    end
    vlb_busy_i = 1'b0;
    @(negedge clock); chk("t5_drain_last", 64'(miss_i_ready), 64'h0);
    cyc();
    @(negedge clock); chk("t5_drain_done", 64'(miss_i_ready), 64'h1);
    cyc();

    // duplicate VPN misses
    miss(52'h77); push_req(2'd0, 52'h77);
    cyc();
`ifndef VLB_MISS_MERGE_EN
    push_req(2'd1, 52'h77);
`endif
    @(negedge clock); chk("t6_dup_ready", 64'(miss_i_ready), 64'h1);
    cyc();
    miss_i_valid = 1'b0;
    cyc();
    resp(2'd0, 1'b1, 1'b0, 52'h88, 4'h7); push_done(52'h77, 1'b0, 52'h88, 4'h7);
    cyc();
    resp(2'd1, 1'b1, 1'b0, 52'h88, 4'h7); push_done(52'h77, 1'b0, 52'h88, 4'h7);
    @(negedge clock); chk("t6_done_first", 64'(done_o_valid), 64'h1);
    cyc();
    vlb_resp_i_valid = 1'b0;
    @(negedge clock); chk("t6_done_second", 64'(done_o_valid), 64'h1);
    cyc();
    @(negedge clock); chk("t6_done_end", 64'(done_o_valid), 64'h0);
    cyc();

    repeat (2) cyc();
    chk("left_req_expect", 64'(req_q.size()), 64'h0);
    chk("left_done_expect", 64'(done_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
